// File: rtl/mult_ctrl.sv
// Shift-add multiplier sequencer: LOAD, then per multiplier bit CHECK -> [ADD] -> SHIFT, then a DONE pulse.
// Moore outputs; done arrives 2 + 2N + popcount(multiplier) cycles after start; start is ignored while busy.
module mult_ctrl #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 q0,
  output logic                 LOAD,
  output logic                 ADD,
  output logic                 SHIFT,
  output logic                 busy,
  output logic                 done,
  output logic [$clog2(N)-1:0] bit_cnt
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
    end else begin
      state <= state_nxt;
      // Counter saturates at the last bit so it never wraps inside an operation.
      if (state == S_LOAD) begin
        bit_cnt <= '0;
      end else if (state == S_SHIFT && bit_cnt != LAST_BIT) begin
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    LOAD      = 1'b0;
    ADD       = 1'b0;
    SHIFT     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        LOAD      = 1'b1;
        state_nxt = S_CHECK;
      end
      S_CHECK: begin
        state_nxt = q0 ? S_ADD : S_SHIFT;
      end
      S_ADD: begin
        ADD       = 1'b1;
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        SHIFT     = 1'b1;
        state_nxt = (bit_cnt == LAST_BIT) ? S_DONE : S_CHECK;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: shift-add datapath model, queue-based cycle-schedule model, directed and random operations.
module tb_mult_ctrl;
  localparam int N   = 4;
  localparam int CW  = $clog2(N);
  localparam int RW  = 2 * N + 1;
  localparam int N6  = 6;
  localparam int CW6 = $clog2(N6);
  localparam int RW6 = 2 * N6 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1, start = 1'b1;
  logic          load, add, shift, busy, done;
  logic [CW-1:0] bit_cnt;
  logic [RW-1:0] regs = '0;
  logic [N-1:0]  mplier = '0, mcand = '0;

  logic           reset6 = 1'b1, start6 = 1'b0;
  logic           load6, add6, shift6, busy6, done6;
  logic [CW6-1:0] bit_cnt6;
  logic [RW6-1:0] regs6 = '0;
  logic [N6-1:0]  mplier6 = '0, mcand6 = '0;

  int errors = 0;
  int checks = 0;

  mult_ctrl #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .q0(regs[0]),
    .LOAD(load), .ADD(add), .SHIFT(shift), .busy(busy), .done(done), .bit_cnt(bit_cnt)
  );

  mult_ctrl #(.N(N6)) dut6 (
    .clk(clk), .reset(reset6), .start(start6), .q0(regs6[0]),
    .LOAD(load6), .ADD(add6), .SHIFT(shift6), .busy(busy6), .done(done6), .bit_cnt(bit_cnt6)
  );

  // Datapath register {carry, sum, multiplier} driven by the controller's commands.
  always @(posedge clk) begin
    if (load) regs <= {1'b0, {N{1'b0}}, mplier};
    else if (add) regs[RW-1:N] <= {1'b0, regs[2*N-1:N]} + {1'b0, mcand};
    else if (shift) regs <= regs >> 1;
  end

  always @(posedge clk) begin
    if (load6) regs6 <= {1'b0, {N6{1'b0}}, mplier6};
    else if (add6) regs6[RW6-1:N6] <= {1'b0, regs6[2*N6-1:N6]} + {1'b0, mcand6};
    else if (shift6) regs6 <= regs6 >> 1;
  end

  // Reference model: an accepted start expands into the whole per-cycle output schedule.
  typedef struct packed {
    logic          load, add, shift, busy, done;
    logic          cnt_chk;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sched[$];
  exp_t          cur = '0;
  logic [2*N-1:0] prod_exp = '0;

  function automatic exp_t mk(input logic l, a, s, b, d, c, input logic [CW-1:0] n);
    mk = {l, a, s, b, d, c, n};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      sched.delete();
      cur = mk(0, 0, 0, 0, 0, 1, '0);
    end else begin
      if (!cur.busy && start) begin
        prod_exp = {{N{1'b0}}, mplier} * {{N{1'b0}}, mcand};
        sched.push_back(mk(1, 0, 0, 1, 0, 0, '0));
        for (int i = 0; i < N; i++) begin
          sched.push_back(mk(0, 0, 0, 1, 0, 1, CW'(i)));
          if (mplier[i]) sched.push_back(mk(0, 1, 0, 1, 0, 1, CW'(i)));
          sched.push_back(mk(0, 0, 1, 1, 0, 1, CW'(i)));
        end
        sched.push_back(mk(0, 0, 0, 1, 1, 1, CW'(N - 1)));
      end
      if (sched.size() > 0) cur = sched.pop_front();
      else if (cur.busy) cur = mk(0, 0, 0, 0, 0, 0, '0);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // One cycle: advance to the falling edge and compare every output against the model.
  task automatic tick();
    @(negedge clk);
    chk("outputs{LOAD,ADD,SHIFT,busy,done}", 32'({load, add, shift, busy, done}),
        32'({cur.load, cur.add, cur.shift, cur.busy, cur.done}));
    if (cur.cnt_chk) chk("bit_cnt", 32'(bit_cnt), 32'(cur.cnt));
    if (cur.done) chk("product_at_done", 32'(regs), 32'({1'b0, prod_exp}));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!busy) break;
    end
    chk("wait_idle_busy", 32'(busy), 32'd0);
  endtask

  // Called at a falling edge while idle; the next rising edge is edge 0.
  task automatic run_op(input string nm, input logic [N-1:0] a, input logic [N-1:0] b, input bit poke,
                        input int exp_done, input int exp_add, input int exp_shift, input int exp_reg);
    int done_cyc = 0, n_load = 0, n_done = 0, add_m = 0, shift_m = 0;
    logic [RW-1:0] r = '0;
    mplier = a;
    mcand  = b;
    start  = 1'b1;
    for (int k = 1; k <= exp_done + 2; k++) begin
      tick();
      start = poke && (k <= exp_done);
      if (load) n_load++;
      if (add) add_m |= (1 << k);
      if (shift) shift_m |= (1 << k);
      if (done) begin
        n_done++;
        if (done_cyc == 0) begin
          done_cyc = k;
          r = regs;
        end
      end
    end
    chk({nm, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
    chk({nm, " add_cycles"}, 32'(add_m), 32'(exp_add));
    chk({nm, " shift_cycles"}, 32'(shift_m), 32'(exp_shift));
    chk({nm, " register"}, 32'(r), 32'(exp_reg));
    chk({nm, " load_count"}, 32'(n_load), 32'd1);
    chk({nm, " done_count"}, 32'(n_done), 32'd1);
  endtask

  initial begin
    int d = 0, second_load = 0, n_done = 0;
    logic [RW6-1:0] r6 = '0;

    // Reset held two cycles with start high, then released with start still high.
    tick();
    chk("reset_outputs", 32'({load, add, shift, busy, done}), 32'd0);
    chk("reset_bit_cnt", 32'(bit_cnt), 32'd0);
    tick();
    chk("reset_outputs_2", 32'({load, add, shift, busy, done}), 32'd0);
    reset = 1'b0;
    tick();
    chk("load_after_reset", 32'(load), 32'd1);
    start = 1'b0;
    wait_idle();

    run_op("9x8", 4'd9, 4'd8, 1'b0, 12, 'h408, 'h950, 72);
    run_op("0x7", 4'd0, 4'd7, 1'b0, 10, 'h0, 'h2A8, 0);
    run_op("15x15_poked", 4'd15, 4'd15, 1'b1, 14, 'h1248, 'h2490, 225);

    // start held high: done at 10, one IDLE cycle, next LOAD at 12.
    mplier = 4'd0;
    mcand  = 4'd3;
    start  = 1'b1;
    d = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (done && d == 0) d = k;
      if (load && k > 1 && second_load == 0) second_load = k;
    end
    chk("held_start done_cycle", 32'(d), 32'd10);
    chk("held_start next_load", 32'(second_load), 32'd12);
    start = 1'b0;
    wait_idle();

    // Reset in the cycle after the second SHIFT discards the operation.
    mplier = 4'd9;
    mcand  = 4'd8;
    start  = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      start = 1'b0;
      if (k >= 8 && done) n_done++;
      if (k == 7) reset = 1'b1;
      if (k == 8) begin
        chk("midop_reset_outputs", 32'({load, add, shift, busy, done}), 32'd0);
        chk("midop_reset_bit_cnt", 32'(bit_cnt), 32'd0);
        reset = 1'b0;
      end
    end
    chk("midop_reset no_done", 32'(n_done), 32'd0);
    run_op("3x5", 4'd3, 4'd5, 1'b0, 12, 'h48, 'hA90, 15);

    // Wider instance: 9 x 8 with N=6.
    reset6 = 1'b0;
    tick();
    mplier6 = 6'd9;
    mcand6  = 6'd8;
    start6  = 1'b1;
    d = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      start6 = 1'b0;
      if (done6 && d == 0) begin
        d  = k;
        r6 = regs6;
      end
    end
    chk("n6 done_cycle", 32'(d), 32'd16);
    chk("n6 register", 32'(r6), 32'd72);

    // Random operands, random start pokes and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (!cur.busy) begin
        mplier = N'($urandom);
        mcand  = N'($urandom);
      end
      start = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 59) == 0);
    end
    reset = 1'b0;
    start = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
